// File: rtl/fault_injector_multi.sv
// fault_injector_multi: LFSR-paced, round-robin fault pulse generator driving GATE_COUNT gate lines.
// Define FAULT_INJ_STATS_EN to build the saturating lifetime injection counter behind inject_count.
module fault_injector_multi #(
    parameter int unsigned GATE_COUNT = 4,
    parameter logic [11:0] RAND_SEED  = 12'hAAA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  logic_reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            threshold,
    input  logic [3:0]            pulse_len,
    input  logic [7:0]            burst_len,
    input  logic [GATE_COUNT-1:0] gate_mask,
    output logic [GATE_COUNT-1:0] fault_out,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           inject_count
);

    localparam int unsigned      TGT_W     = (GATE_COUNT > 1) ? $clog2(GATE_COUNT) : 1;
    localparam logic [TGT_W-1:0] TGT_LAST  = TGT_W'(GATE_COUNT - 1);
    // An all-zero Galois LFSR locks up, so a zero seed is replaced.
    localparam logic [11:0]      SEED      = (RAND_SEED == 12'h000) ? 12'h001 : RAND_SEED;
    localparam logic [11:0]      LFSR_TAPS = 12'hE08;

    typedef enum logic [1:0] {IDLE, WAIT, INJECT, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [11:0]             lfsr;
    logic [7:0]              thr_q;
    logic [3:0]              plen_q;
    logic [GATE_COUNT-1:0]   mask_q;
    logic [7:0]              remaining;
    logic [3:0]              pulse_cnt;
    logic [TGT_W-1:0]        tgt;
    logic [GATE_COUNT-1:0]   hit_vec;
    logic                    hit;
    logic                    fire;
    logic                    pulse_last;
    logic                    inject_entry;

    assign fire         = (lfsr[7:0] < thr_q);
    assign pulse_last   = (pulse_cnt == plen_q - 4'd1);
    assign hit_vec      = (GATE_COUNT'(1) << tgt) & mask_q;
    assign hit          = |hit_vec;
    assign inject_entry = (state == WAIT) && (state_next == INJECT);

    assign busy = (state == WAIT) || (state == INJECT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        if (logic_reset) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = WAIT;
                WAIT: begin
                    if (abort)     state_next = IDLE;
                    else if (fire) state_next = INJECT;
                end
                INJECT: begin
                    if (abort)           state_next = IDLE;
                    else if (pulse_last) state_next = (remaining == 8'd0) ? DONE : WAIT;
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Campaign datapath; everything keys off state/state_next so abort and logic_reset need no extra paths.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr      <= SEED;
            thr_q     <= '0;
            plen_q    <= '0;
            mask_q    <= '0;
            remaining <= '0;
            pulse_cnt <= '0;
            tgt       <= '0;
            fault_out <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand side sees pre-edge values.
            lfsr <= {1'b0, lfsr[11:1]} ^ (lfsr[0] ? LFSR_TAPS : 12'h000);

            if (state == IDLE && state_next == WAIT) begin
                thr_q     <= threshold;
                plen_q    <= (pulse_len == 4'd0) ? 4'd1 : pulse_len;
                mask_q    <= gate_mask;
                remaining <= (burst_len == 8'd0) ? 8'd1 : burst_len;
            end

            if (logic_reset) begin
                tgt <= '0;
            end else if (inject_entry) begin
                tgt <= (tgt == TGT_LAST) ? '0 : tgt + TGT_W'(1);
            end

            if (inject_entry) begin
                pulse_cnt <= '0;
                if (hit) remaining <= remaining - 8'd1;
            end else if (state == INJECT) begin
                pulse_cnt <= pulse_cnt + 4'd1;
            end

            if (state_next != INJECT) begin
                fault_out <= '0;
            end else if (inject_entry) begin
                fault_out <= hit_vec;
            end
        end
    end

`ifdef FAULT_INJ_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            inject_count <= '0;
        end else if (inject_entry && hit && inject_count != 16'hFFFF) begin
            inject_count <= inject_count + 16'd1;
        end
    end
`else
    assign inject_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fault_injector_multi.sv
// Directed bench for fault_injector_multi: burst sequencing, masking, abort, resets and LFSR seeding.
module tb_fault_injector_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        logic_reset;
    logic        start;
    logic        abort;
    logic [7:0]  threshold;
    logic [3:0]  pulse_len;
    logic [7:0]  burst_len;
    logic [3:0]  gate_mask;
    logic [3:0]  fault_out;
    logic        busy;
    logic        done;
    logic [15:0] inject_count;
    logic [3:0]  fz_fault;
    logic        fz_busy;
    logic        fz_done;
    logic [15:0] fz_count;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef FAULT_INJ_STATS_EN
    localparam logic [15:0] STATS_MASK = 16'hFFFF;
`else
    localparam logic [15:0] STATS_MASK = 16'h0000;
`endif

    logic [11:0] model_lfsr;
    logic [3:0]  pv[$];
    int          pl[$];
    int          done_seen;
    int          busy_gap;
    int          multi_hot;
    logic [3:0]  trace[2][120];

    always #5 clk = ~clk;

    fault_injector_multi dut (
        .clk(clk), .reset(reset), .logic_reset(logic_reset), .start(start), .abort(abort),
        .threshold(threshold), .pulse_len(pulse_len), .burst_len(burst_len), .gate_mask(gate_mask),
        .fault_out(fault_out), .busy(busy), .done(done), .inject_count(inject_count)
    );

    fault_injector_multi #(.GATE_COUNT(4), .RAND_SEED(12'h000)) dut_z (
        .clk(clk), .reset(reset), .logic_reset(logic_reset), .start(start), .abort(abort),
        .threshold(threshold), .pulse_len(pulse_len), .burst_len(burst_len), .gate_mask(gate_mask),
        .fault_out(fz_fault), .busy(fz_busy), .done(fz_done), .inject_count(fz_count)
    );

    function automatic logic [11:0] lfsr_step(input logic [11:0] x);
        return {1'b0, x[11:1]} ^ (x[0] ? 12'hE08 : 12'h000);
    endfunction

    // Reference LFSR for the zero-seed instance, which must behave as seed 1.
    always @(posedge clk) model_lfsr <= !reset ? 12'h001 : lfsr_step(model_lfsr);

    function automatic logic [15:0] exp_cnt(input int n);
        return 16'(n) & STATS_MASK;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_logic_reset();
        @(negedge clk); logic_reset = 1'b1;
        @(negedge clk); logic_reset = 1'b0;
    endtask

    // Start a campaign, then scramble the inputs to show only latched values matter.
    task automatic start_campaign(input logic [7:0] thr, input logic [3:0] pl_in,
                                  input logic [7:0] bl, input logic [3:0] m);
        @(negedge clk);
        threshold = thr; pulse_len = pl_in; burst_len = bl; gate_mask = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0; threshold = 8'h00; pulse_len = 4'hF; burst_len = 8'h00; gate_mask = 4'h0;
    endtask

    task automatic collect(input int budget);
        logic [3:0] cur;
        int         len;
        pv.delete(); pl.delete();
        done_seen = 0; busy_gap = 0; multi_hot = 0; cur = 4'h0; len = 0;
        for (int i = 0; i < budget && done_seen == 0; i++) begin
            @(negedge clk);
            if ($countones(fault_out) > 1) multi_hot++;
            if (done) done_seen++;
            else if (!busy) busy_gap++;
            if (fault_out != cur) begin
                if (cur != 4'h0) begin pv.push_back(cur); pl.push_back(len); end
                cur = fault_out; len = 1;
            end else begin
                len++;
            end
        end
        if (cur != 4'h0) begin pv.push_back(cur); pl.push_back(len); end
        @(negedge clk);
        if (done) done_seen++;
    endtask

    task automatic verify_burst(input string tag, input int n, input logic [3:0] v0,
                                input logic [3:0] v1, input logic [3:0] v2, input int len);
        logic [3:0] ev[3];
        ev[0] = v0; ev[1] = v1; ev[2] = v2;
        check({tag, "_npulse"}, pv.size(), n);
        for (int i = 0; i < n && i < pv.size(); i++) begin
            check($sformatf("%s_val%0d", tag, i), pv[i], ev[i]);
            check($sformatf("%s_len%0d", tag, i), pl[i], len);
        end
        check({tag, "_done_once"}, done_seen, 1);
        check({tag, "_busy_gap"}, busy_gap, 0);
        check({tag, "_onehot"}, multi_hot, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic wait_fault(input logic [3:0] want, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            found = (want == 4'h0) ? (fault_out != 4'h0) : (fault_out == want);
        end
        check(tag, found, 1);
    endtask

    task automatic seed_run(input int idx, output int k_exp);
        logic [11:0] x;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        threshold = 8'h40; pulse_len = 4'd1; burst_len = 8'd4; gate_mask = 4'hF; start = 1'b1;
        x = model_lfsr;
        k_exp = -1;
        for (int j = 1; j < 100 && k_exp < 0; j++) begin
            x = lfsr_step(x);
            if (x[7:0] < 8'h40) k_exp = j;
        end
        trace[idx][0] = 4'h0;
        for (int j = 1; j < 120; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            trace[idx][j] = fz_fault;
        end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
    endtask

    initial begin
        int hot;
        int cnt;
        int k0;
        int k1;
        int first;
        int diffs;

        reset = 1'b0; logic_reset = 1'b0; start = 1'b0; abort = 1'b0;
        threshold = 8'h00; pulse_len = 4'h0; burst_len = 8'h00; gate_mask = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_fault", fault_out, 4'h0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", inject_count, 16'h0);
        check("rst_z_busy_done", {fz_busy, fz_done}, 2'b00);
        check("rst_z_count", fz_count, 16'h0);
        reset = 1'b1;

        // Full-mask burst of 3, pulse width 2: bits 0,1,2 in turn.
        do_logic_reset();
        start_campaign(8'hFF, 4'd2, 8'd3, 4'hF);
        collect(400);
        verify_burst("basic", 3, 4'h1, 4'h2, 4'h4, 2);
        check("basic_count", inject_count, exp_cnt(3));

        // Mask 0101: slot for bit 1 produces no output and is not counted.
        do_logic_reset();
        start_campaign(8'hFF, 4'd1, 8'd2, 4'b0101);
        collect(400);
        verify_burst("masked", 2, 4'h1, 4'h4, 4'h0, 1);
        check("masked_count", inject_count, exp_cnt(5));

        // Zero pulse_len and burst_len act as 1.
        do_logic_reset();
        start_campaign(8'hFF, 4'd0, 8'd0, 4'hF);
        collect(400);
        verify_burst("zero_len", 1, 4'h1, 4'h0, 4'h0, 1);
        check("zero_len_count", inject_count, exp_cnt(6));

        // Abort in the second cycle of the second pulse.
        do_logic_reset();
        start_campaign(8'hFF, 4'd5, 8'd4, 4'hF);
        wait_fault(4'h2, "abort_reach_pulse2");
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_fault", fault_out, 4'h0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        cnt = 0;
        repeat (5) begin @(negedge clk); if (done) cnt++; end
        check("abort_no_done", cnt, 0);
        check("abort_count", inject_count, exp_cnt(8));

        // Threshold 0 never fires.
        do_logic_reset();
        start_campaign(8'h00, 4'd1, 8'd1, 4'hF);
        hot = 0; cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (fault_out != 4'h0) hot++;
            if (!busy) cnt++;
        end
        check("thr0_fault", hot, 0);
        check("thr0_busy_low", cnt, 0);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("thr0_abort_busy", busy, 0);

        // All-zero mask never completes.
        do_logic_reset();
        start_campaign(8'hFF, 4'd1, 8'd1, 4'h0);
        hot = 0; cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (fault_out != 4'h0) hot++;
            if (done) cnt++;
        end
        check("mask0_fault", hot, 0);
        check("mask0_done", cnt, 0);
        check("mask0_busy", busy, 1);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("mask0_abort_busy", busy, 0);
        check("mask0_count", inject_count, exp_cnt(8));

        // logic_reset mid-pulse keeps the statistic.
        do_logic_reset();
        start_campaign(8'hFF, 4'd5, 8'd1, 4'hF);
        wait_fault(4'h0, "lrst_reach_pulse");
        logic_reset = 1'b1; @(negedge clk); logic_reset = 1'b0;
        check("lrst_fault", fault_out, 4'h0);
        check("lrst_busy_done", {busy, done}, 2'b00);
        check("lrst_count", inject_count, exp_cnt(9));

        // Hard reset mid-pulse dominates start, abort and logic_reset.
        do_logic_reset();
        start_campaign(8'hFF, 4'd5, 8'd1, 4'hF);
        wait_fault(4'h0, "rst_reach_pulse");
        reset = 1'b0; start = 1'b1; abort = 1'b1; logic_reset = 1'b1;
        @(negedge clk);
        check("midrst_fault", fault_out, 4'h0);
        check("midrst_busy_done", {busy, done}, 2'b00);
        check("midrst_count", inject_count, 16'h0);
        @(negedge clk);
        check("midrst_start_blocked", busy, 0);
        reset = 1'b1; start = 1'b0; abort = 1'b0; logic_reset = 1'b0;

        // Zero seed behaves as seed 1 and repeats exactly after reset.
        seed_run(0, k0);
        seed_run(1, k1);
        first = -1;
        for (int j = 0; j < 120 && first < 0; j++) if (trace[0][j] != 4'h0) first = j;
        check("seed_first_fire", first, k0 + 1);
        if (first >= 0) check("seed_first_bit", trace[0][first], 4'h1);
        diffs = 0;
        for (int j = 0; j < 120; j++) if (trace[0][j] != trace[1][j]) diffs++;
        check("seed_repeat", diffs, 0);
        check("seed_k_repeat", k1, k0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
